pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush/forward sequencer for the 5-stage core. Detects load-use hazards, resolves EX-stage

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the hazard controller
// Purpose: FSM state encoding, forwarding-select codes and the forwarding priority helper.
// Ports:   none (package).
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // MEM holds the younger result, so it wins over WB.
  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_REG;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// rtl/pipeline_hazard_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
// Purpose: event counter that holds at all-ones instead of wrapping.
// Ports:   clk_i clock, clr_i synchronous clear (wins over inc_i),
//          inc_i count enable, cnt_o current count.
module pipeline_hazard_ctrl_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (inc_i && !(&cnt_q))  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forward sequencer for the 5-stage core
// Purpose: load-use stall, EX mispredict redirect, EX operand forwarding and a
//          debug halt/drain FSM (RUN -> DRAIN -> HALTED -> RUN), plus saturating
//          mispredict and load-use counters.
// Ports:   clk_i, reset_ni (synchronous, active-low);
//          rs1_d_i/rs2_d_i ID sources; rs1_e_i/rs2_e_i/rd_e_i/mem_read_e_i EX;
//          rd_m_i/reg_write_m_i MEM; rd_w_i/reg_write_w_i WB;
//          branch_e_i/jump_e_i/pred_taken_e_i/actual_taken_e_i/target_e_i/pc_next_e_i
//          branch resolution; halt_req_i/resume_req_i debug levels;
//          stall_f_o/stall_d_o/flush_d_o/flush_e_o pipeline control;
//          redirect_valid_o/redirect_pc_o fetch redirect; forward_a_e_o/forward_b_e_o;
//          halt_ack_o; mispredict_cnt_o/loaduse_cnt_o.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int REG_W        = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [REG_W-1:0]  rs1_d_i,
  input  logic [REG_W-1:0]  rs2_d_i,
  input  logic [REG_W-1:0]  rs1_e_i,
  input  logic [REG_W-1:0]  rs2_e_i,
  input  logic [REG_W-1:0]  rd_e_i,
  input  logic              mem_read_e_i,
  input  logic [REG_W-1:0]  rd_m_i,
  input  logic              reg_write_m_i,
  input  logic [REG_W-1:0]  rd_w_i,
  input  logic              reg_write_w_i,
  input  logic              branch_e_i,
  input  logic              jump_e_i,
  input  logic              pred_taken_e_i,
  input  logic              actual_taken_e_i,
  input  logic [ADDR_W-1:0] target_e_i,
  input  logic [ADDR_W-1:0] pc_next_e_i,
  input  logic              halt_req_i,
  input  logic              resume_req_i,
  output logic              stall_f_o,
  output logic              stall_d_o,
  output logic              flush_d_o,
  output logic              flush_e_o,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic [1:0]        forward_a_e_o,
  output logic [1:0]        forward_b_e_o,
  output logic              halt_ack_o,
  output logic [CNT_W-1:0]  mispredict_cnt_o,
  output logic [CNT_W-1:0]  loaduse_cnt_o
);

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  state_e         state_q, state_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;

  logic mispredict;
  logic load_use;
  logic lu_inc;
  logic mis_inc;

  assign mispredict = (branch_e_i & (pred_taken_e_i ^ actual_taken_e_i)) |
                      (jump_e_i & ~pred_taken_e_i);

  assign load_use = mem_read_e_i && (rd_e_i != '0) &&
                    ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

  // A mispredict makes the ID instruction wrong-path, so the load-use stall is dropped.
  assign lu_inc  = reset_ni && (state_q == ST_RUN) && load_use && !mispredict;
  assign mis_inc = reset_ni && mispredict;

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (halt_req_i) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        // A redirect refills the front end, so the drain has to start over.
        if (mispredict) begin
          drain_cnt_d = '0;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = ST_HALTED;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      ST_HALTED: begin
        if (resume_req_i) state_d = ST_RUN;
      end
      default: begin
        state_d     = ST_RUN;
        drain_cnt_d = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    stall_f_o        = 1'b0;
    stall_d_o        = 1'b0;
    flush_d_o        = 1'b0;
    flush_e_o        = 1'b0;
    redirect_valid_o = 1'b0;
    forward_a_e_o    = FWD_REG;
    forward_b_e_o    = FWD_REG;
    redirect_pc_o    = (actual_taken_e_i | jump_e_i) ? target_e_i : pc_next_e_i;

    if (!reset_ni) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
    end else begin
      forward_a_e_o = fwd_sel(reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs1_e_i),
                              reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs1_e_i));
      forward_b_e_o = fwd_sel(reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs2_e_i),
                              reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs2_e_i));

      if (mispredict) begin
        redirect_valid_o = 1'b1;
        flush_d_o        = 1'b1;
        flush_e_o        = 1'b1;
      end

      unique case (state_q)
        ST_RUN: begin
          if (load_use && !mispredict) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            flush_e_o = 1'b1;
          end
        end
        ST_DRAIN, ST_HALTED: begin
          // Hold IF/ID and keep feeding bubbles; redirect_valid overrides stall_f at the PC.
          stall_f_o = 1'b1;
          stall_d_o = 1'b1;
          flush_e_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign halt_ack_o = (state_q == ST_HALTED);

  pipeline_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_mis_cnt (
    .clk_i (clk_i),
    .clr_i (~reset_ni),
    .inc_i (mis_inc),
    .cnt_o (mispredict_cnt_o)
  );

  pipeline_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk_i (clk_i),
    .clr_i (~reset_ni),
    .inc_i (lu_inc),
    .cnt_o (loaduse_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int ADDR_W = 5;
  localparam int REG_W  = 5;
  localparam int DRAIN  = 3;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic             sf;
    logic             sd;
    logic             fd;
    logic             fe;
    logic             rv;
    logic [ADDR_W-1:0] pc;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             ack;
    logic [CNT_W-1:0] mc;
    logic [CNT_W-1:0] lc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_ni;
  logic [REG_W-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic mem_read_e, reg_write_m, reg_write_w;
  logic branch_e, jump_e, pred_taken_e, actual_taken_e;
  logic [ADDR_W-1:0] target_e, pc_next_e;
  logic halt_req, resume_req;
  logic stall_f, stall_d, flush_d, flush_e, redirect_valid, halt_ack;
  logic [ADDR_W-1:0] redirect_pc;
  logic [1:0] forward_a_e, forward_b_e;
  logic [CNT_W-1:0] mispredict_cnt, loaduse_cnt;

  int checks = 0;
  int errors = 0;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e, mon_a;
  string mon_n;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .ADDR_W(ADDR_W), .REG_W(REG_W), .DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rs1_e_i(rs1_e), .rs2_e_i(rs2_e),
    .rd_e_i(rd_e), .mem_read_e_i(mem_read_e),
    .rd_m_i(rd_m), .reg_write_m_i(reg_write_m),
    .rd_w_i(rd_w), .reg_write_w_i(reg_write_w),
    .branch_e_i(branch_e), .jump_e_i(jump_e),
    .pred_taken_e_i(pred_taken_e), .actual_taken_e_i(actual_taken_e),
    .target_e_i(target_e), .pc_next_e_i(pc_next_e),
    .halt_req_i(halt_req), .resume_req_i(resume_req),
    .stall_f_o(stall_f), .stall_d_o(stall_d), .flush_d_o(flush_d), .flush_e_o(flush_e),
    .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
    .forward_a_e_o(forward_a_e), .forward_b_e_o(forward_b_e),
    .halt_ack_o(halt_ack),
    .mispredict_cnt_o(mispredict_cnt), .loaduse_cnt_o(loaduse_cnt)
  );

  function automatic exp_t mk(input logic sf, input logic sd, input logic fd, input logic fe,
                              input logic rv, input logic [ADDR_W-1:0] pc,
                              input logic [1:0] fa, input logic [1:0] fb, input logic ack,
                              input logic [CNT_W-1:0] mc, input logic [CNT_W-1:0] lc);
    return '{sf: sf, sd: sd, fd: fd, fe: fe, rv: rv, pc: pc, fa: fa, fb: fb,
             ack: ack, mc: mc, lc: lc};
  endfunction

  task automatic idle();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    mem_read_e = 0; reg_write_m = 0; reg_write_w = 0;
    branch_e = 0; jump_e = 0; pred_taken_e = 0; actual_taken_e = 0;
    target_e = '0; pc_next_e = '0; halt_req = 0; resume_req = 0;
  endtask

  task automatic push(input string n, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // Monitor: outputs are combinational every cycle, so one expectation is consumed per cycle.
  always @(negedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      mon_a = {stall_f, stall_d, flush_d, flush_e, redirect_valid, redirect_pc,
               forward_a_e, forward_b_e, halt_ack, mispredict_cnt, loaduse_cnt};
      checks++;
      if (mon_a !== mon_e)
        begin
          errors++;
          $display("FAIL %s actual=%p required=%p", mon_n, mon_a, mon_e);
        end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_ni = 0;
    idle();
    // Reset: hazard/forward inputs active but outputs forced
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle();
      mem_read_e = 1; rd_e = 5; rs1_d = 5;
      reg_write_m = 1; rd_m = 3; rs1_e = 3;
      push("reset", mk(0,0,1,1,0,0,2'b00,2'b00,0,0,0));
    end
    @(negedge clk); reset_ni = 1; idle();
    push("idle", mk(0,0,0,0,0,0,2'b00,2'b00,0,0,0));

    // Load-use
    @(negedge clk); idle(); mem_read_e = 1; rd_e = 5; rs1_d = 5;
    push("lu_rs1", mk(1,1,0,1,0,0,2'b00,2'b00,0,0,0));
    @(negedge clk); idle();
    push("lu_cnt1", mk(0,0,0,0,0,0,2'b00,2'b00,0,0,1));
    @(negedge clk); idle(); mem_read_e = 1; rd_e = 7; rs2_d = 7;
    push("lu_rs2", mk(1,1,0,1,0,0,2'b00,2'b00,0,0,1));
    @(negedge clk); idle(); mem_read_e = 1; rd_e = 0; rs1_d = 0;
    push("lu_x0", mk(0,0,0,0,0,0,2'b00,2'b00,0,0,2));
    @(negedge clk); idle(); mem_read_e = 0; rd_e = 5; rs1_d = 5;
    push("lu_noload", mk(0,0,0,0,0,0,2'b00,2'b00,0,0,2));

    // Mispredict
    @(negedge clk); idle(); branch_e = 1; actual_taken_e = 1; target_e = 12; pc_next_e = 3;
    push("br_nt_t", mk(0,0,1,1,1,12,2'b00,2'b00,0,0,2));
    @(negedge clk); idle(); branch_e = 1; pred_taken_e = 1; target_e = 12; pc_next_e = 7;
    push("br_t_nt", mk(0,0,1,1,1,7,2'b00,2'b00,0,1,2));
    @(negedge clk); idle(); branch_e = 1; pred_taken_e = 1; actual_taken_e = 1; target_e = 12;
    push("br_ok", mk(0,0,0,0,0,12,2'b00,2'b00,0,2,2));
    @(negedge clk); idle(); jump_e = 1; target_e = 9;
    push("jmp_miss", mk(0,0,1,1,1,9,2'b00,2'b00,0,2,2));
    @(negedge clk); idle(); jump_e = 1; pred_taken_e = 1; target_e = 9;
    push("jmp_ok", mk(0,0,0,0,0,9,2'b00,2'b00,0,3,2));
    @(negedge clk); idle(); branch_e = 1; actual_taken_e = 1; target_e = 4;
    mem_read_e = 1; rd_e = 5; rs1_d = 5;
    push("lu_and_mis", mk(0,0,1,1,1,4,2'b00,2'b00,0,3,2));
    @(negedge clk); idle();
    push("cnt_after", mk(0,0,0,0,0,0,2'b00,2'b00,0,4,2));

    // Forwarding
    @(negedge clk); idle(); rd_m = 3; rd_w = 3; rs1_e = 3; reg_write_m = 1; reg_write_w = 1;
    push("fwd_a_mem", mk(0,0,0,0,0,0,2'b10,2'b00,0,4,2));
    @(negedge clk); idle(); rd_m = 3; rd_w = 3; rs1_e = 3; reg_write_w = 1;
    push("fwd_a_wb", mk(0,0,0,0,0,0,2'b01,2'b00,0,4,2));
    @(negedge clk); idle(); rd_m = 0; rd_w = 0; rs2_e = 0; reg_write_m = 1; reg_write_w = 1;
    push("fwd_x0", mk(0,0,0,0,0,0,2'b00,2'b00,0,4,2));
    @(negedge clk); idle(); rd_w = 4; rd_m = 4; rs2_e = 4; reg_write_w = 1;
    push("fwd_b_wb", mk(0,0,0,0,0,0,2'b00,2'b01,0,4,2));
    @(negedge clk); idle(); rd_w = 4; rd_m = 4; rs2_e = 4; rs1_e = 4; reg_write_m = 1; reg_write_w = 1;
    push("fwd_ab_mem", mk(0,0,0,0,0,0,2'b10,2'b10,0,4,2));

    // Halt / drain / resume
    @(negedge clk); idle(); halt_req = 1;
    push("halt_req", mk(0,0,0,0,0,0,2'b00,2'b00,0,4,2));
    for (int i = 0; i < DRAIN; i++) begin
      @(negedge clk); idle();
      push("drain", mk(1,1,0,1,0,0,2'b00,2'b00,0,4,2));
    end
    @(negedge clk); idle(); halt_req = 1;
    push("halted", mk(1,1,0,1,0,0,2'b00,2'b00,1,4,2));
    @(negedge clk); idle(); resume_req = 1;
    push("resume", mk(1,1,0,1,0,0,2'b00,2'b00,1,4,2));
    @(negedge clk); idle(); resume_req = 1;
    push("run_resume_ign", mk(0,0,0,0,0,0,2'b00,2'b00,0,4,2));
    @(negedge clk); idle();
    push("run_idle", mk(0,0,0,0,0,0,2'b00,2'b00,0,4,2));

    // Mispredict during drain restarts it
    @(negedge clk); idle(); halt_req = 1;
    push("halt_req2", mk(0,0,0,0,0,0,2'b00,2'b00,0,4,2));
    @(negedge clk); idle();
    push("drain0", mk(1,1,0,1,0,0,2'b00,2'b00,0,4,2));
    @(negedge clk); idle(); branch_e = 1; actual_taken_e = 1; target_e = 20;
    push("drain_mis", mk(1,1,1,1,1,20,2'b00,2'b00,0,4,2));
    for (int i = 0; i < DRAIN; i++) begin
      @(negedge clk); idle();
      push("drain_re", mk(1,1,0,1,0,0,2'b00,2'b00,0,5,2));
    end
    @(negedge clk); idle(); halt_req = 1; resume_req = 1;
    push("halted_both", mk(1,1,0,1,0,0,2'b00,2'b00,1,5,2));
    @(negedge clk); idle();
    push("resume_wins", mk(0,0,0,0,0,0,2'b00,2'b00,0,5,2));

    // Reset in the middle of a drain
    @(negedge clk); idle(); halt_req = 1;
    push("halt_req3", mk(0,0,0,0,0,0,2'b00,2'b00,0,5,2));
    @(negedge clk); idle();
    push("drain0b", mk(1,1,0,1,0,0,2'b00,2'b00,0,5,2));
    @(negedge clk); idle(); reset_ni = 0;
    push("reset_drain", mk(0,0,1,1,0,0,2'b00,2'b00,0,5,2));
    @(negedge clk); idle(); reset_ni = 1;
    push("post_reset", mk(0,0,0,0,0,0,2'b00,2'b00,0,0,0));
    @(negedge clk); idle();
    push("post_reset2", mk(0,0,0,0,0,0,2'b00,2'b00,0,0,0));

    // Counter saturation
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); idle(); mem_read_e = 1; rd_e = 5; rs1_d = 5;
      push("lu_sat", mk(1,1,0,1,0,0,2'b00,2'b00,0,0, CNT_W'((i > 15) ? 15 : i)));
    end
    for (int i = 0; i < 18; i++) begin
      @(negedge clk); idle(); jump_e = 1; target_e = 1;
      push("mis_sat", mk(0,0,1,1,1,1,2'b00,2'b00,0, CNT_W'((i > 15) ? 15 : i), 15));
    end
    @(negedge clk); idle();
    push("sat_hold", mk(0,0,0,0,0,0,2'b00,2'b00,0,15,15));

    @(negedge clk); #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
